// File: rtl/axil_gpio_ctrl.sv
// AXI4-Lite GPIO slave: per-pad direction, output data, atomic set/clear, synchronised input.
// Optional edge interrupts (IER/EDGE/ISR, IRQ) are built when GPIO_IRQ_EN is defined.
module axil_gpio_ctrl #(
  parameter int GPIO_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  inout  wire  [GPIO_W-1:0] IOPORT,
  output logic              IRQ
);

  localparam logic [2:0] SEL_MODER   = 3'd0;
  localparam logic [2:0] SEL_ODR     = 3'd1;
  localparam logic [2:0] SEL_IDR     = 3'd2;
  localparam logic [2:0] SEL_OSET    = 3'd3;
  localparam logic [2:0] SEL_OCLR    = 3'd4;
`ifdef GPIO_IRQ_EN
  localparam logic [2:0] SEL_IER     = 3'd5;
  localparam logic [2:0] SEL_EDGE    = 3'd6;
  localparam logic [2:0] SEL_ISR     = 3'd7;
`endif
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  function automatic logic sel_mapped(input logic [2:0] sel);
`ifdef GPIO_IRQ_EN
    return (sel <= 3'd7);
`else
    return (sel <= SEL_OCLR);
`endif
  endfunction

  logic              aw_held_r, w_held_r, bvalid_r, rvalid_r;
  logic [2:0]        aw_sel_r;
  logic [31:0]       w_data_r, rdata_r, strb_full_s, rd_data_s;
  logic [3:0]        w_strb_r;
  logic [1:0]        bresp_r, rresp_r, rd_resp_s;
  logic [GPIO_W-1:0] moder_r, odr_r, moder_nxt_s, odr_nxt_s, wmask_s, wbits_s, idr_s;
  logic [GPIO_W-1:0] sync_r [SYNC_STAGES];
  logic              aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic              unused_s;

  assign AWREADY  = ~aw_held_r & ~bvalid_r;
  assign WREADY   = ~w_held_r & ~bvalid_r;
  assign ARREADY  = ~rvalid_r;
  assign BVALID   = bvalid_r;
  assign BRESP    = bresp_r;
  assign RVALID   = rvalid_r;
  assign RRESP    = rresp_r;
  assign RDATA    = rdata_r;
  assign aw_hs_s  = AWVALID & AWREADY;
  assign w_hs_s   = WVALID & WREADY;
  assign ar_hs_s  = ARVALID & ARREADY;
  assign commit_s = aw_held_r & w_held_r;

  assign strb_full_s = strb_mask(w_strb_r);
  assign wmask_s     = strb_full_s[GPIO_W-1:0];
  assign wbits_s     = w_data_r[GPIO_W-1:0] & wmask_s;
  assign idr_s       = sync_r[SYNC_STAGES-1];
  assign unused_s    = ^{AWADDR, ARADDR, w_data_r, strb_full_s};

  for (genvar g = 0; g < GPIO_W; g++) begin : g_pad
    assign IOPORT[g] = moder_r[g] ? odr_r[g] : 1'bz;
  end

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] ier_r, edge_r, isr_r, idr_prev_r;
  logic [GPIO_W-1:0] ier_nxt_s, edge_nxt_s, isr_w1c_s, edge_ev_s;
  logic              irq_r;

  assign edge_ev_s = (edge_r & idr_s & ~idr_prev_r) | (~edge_r & ~idr_s & idr_prev_r);
  assign IRQ       = irq_r;

  // Interrupt state; a fresh edge overrides a same-cycle W1C of that bit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ier_r      <= {GPIO_W{1'b0}};
      edge_r     <= {GPIO_W{1'b0}};
      isr_r      <= {GPIO_W{1'b0}};
      idr_prev_r <= {GPIO_W{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      ier_r      <= ier_nxt_s;
      edge_r     <= edge_nxt_s;
      isr_r      <= (isr_r & ~isr_w1c_s) | edge_ev_s;
      idr_prev_r <= idr_s;
      irq_r      <= |(isr_r & ier_r);
    end
  end
`else
  assign IRQ = 1'b0;
`endif

  // Register write decode, applied only in the commit cycle.
  always_comb begin
    moder_nxt_s = moder_r;
    odr_nxt_s   = odr_r;
`ifdef GPIO_IRQ_EN
    ier_nxt_s   = ier_r;
    edge_nxt_s  = edge_r;
    isr_w1c_s   = {GPIO_W{1'b0}};
`endif
    if (commit_s) begin
      case (aw_sel_r)
        SEL_MODER: moder_nxt_s = (moder_r & ~wmask_s) | wbits_s;
        SEL_ODR:   odr_nxt_s   = (odr_r & ~wmask_s) | wbits_s;
        SEL_OSET:  odr_nxt_s   = odr_r | wbits_s;
        SEL_OCLR:  odr_nxt_s   = odr_r & ~wbits_s;
`ifdef GPIO_IRQ_EN
        SEL_IER:   ier_nxt_s   = (ier_r & ~wmask_s) | wbits_s;
        SEL_EDGE:  edge_nxt_s  = (edge_r & ~wmask_s) | wbits_s;
        SEL_ISR:   isr_w1c_s   = wbits_s;
`endif
        default:   moder_nxt_s = moder_r;
      endcase
    end else begin
      odr_nxt_s = odr_r;
    end
  end

  // Read decode; write-only registers read as zero.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_resp_s = RESP_OKAY;
    case (ARADDR[4:2])
      SEL_MODER: rd_data_s = 32'(moder_r);
      SEL_ODR:   rd_data_s = 32'(odr_r);
      SEL_IDR:   rd_data_s = 32'(idr_s);
      SEL_OSET:  rd_data_s = 32'h0000_0000;
      SEL_OCLR:  rd_data_s = 32'h0000_0000;
`ifdef GPIO_IRQ_EN
      SEL_IER:   rd_data_s = 32'(ier_r);
      SEL_EDGE:  rd_data_s = 32'(edge_r);
      SEL_ISR:   rd_data_s = 32'(isr_r);
`endif
      default:   rd_resp_s = RESP_SLVERR;
    endcase
  end

  // Write channel: AW and W are held independently until both are present.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_r <= 1'b0;
      aw_sel_r  <= 3'd0;
      w_held_r  <= 1'b0;
      w_data_r  <= 32'h0000_0000;
      w_strb_r  <= 4'h0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      if (commit_s) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= sel_mapped(aw_sel_r) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs_s) begin
          aw_held_r <= 1'b1;
          aw_sel_r  <= AWADDR[4:2];
        end
        if (w_hs_s) begin
          w_held_r <= 1'b1;
          w_data_r <= WDATA;
          w_strb_r <= WSTRB;
        end
        if (bvalid_r && BREADY) begin
          bvalid_r <= 1'b0;
        end
      end
    end
  end

  // Read channel: response registered on AR handshake, held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      rresp_r  <= rd_resp_s;
    end else if (rvalid_r && RREADY) begin
      rvalid_r <= 1'b0;
    end
  end

  // GPIO registers and input synchroniser.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      moder_r <= {GPIO_W{1'b0}};
      odr_r   <= {GPIO_W{1'b0}};
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {GPIO_W{1'b0}};
    end else begin
      moder_r   <= moder_nxt_s;
      odr_r     <= odr_nxt_s;
      sync_r[0] <= IOPORT;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

endmodule

// File: tb/tb_axil_gpio_ctrl.sv
// Scoreboard bench for axil_gpio_ctrl: stimulus pushes expected B/R responses, a monitor checks them.
module tb_axil_gpio_ctrl;
  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic [4:0]  AWADDR = 5'd0, ARADDR = 5'd0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0, BREADY = 1'b1, RREADY = 1'b1;
  logic [31:0] WDATA = 32'h0;
  logic [3:0]  WSTRB = 4'h0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, IRQ;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  wire  [7:0]  pads;
  logic [7:0]  tb_oe = 8'h00, tb_val = 8'h00, pad_at_b;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  rexp_t      r_q[$];
  logic [1:0] b_q[$];
  int n_tests = 0, n_fail = 0;

  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign pads[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  axil_gpio_ctrl #(.GPIO_W(8), .ADDR_W(5), .SYNC_STAGES(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .IOPORT(pads), .IRQ(IRQ)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Monitor: compare every completed B/R handshake against the scoreboard
  always @(negedge ACLK) begin
    if (!ARESET && RVALID && RREADY) begin
      if (r_q.size() == 0) begin
        check("r_unexpected", 32'd1, 32'd0);
      end else begin
        rexp_t e;
        e = r_q.pop_front();
        check("rdata", RDATA, e.data);
        check("rresp", {30'd0, RRESP}, {30'd0, e.resp});
      end
    end
    if (!ARESET && BVALID && BREADY) begin
      if (b_q.size() == 0) begin
        check("b_unexpected", 32'd1, 32'd0);
      end else begin
        logic [1:0] eb;
        eb = b_q.pop_front();
        check("bresp", {30'd0, BRESP}, {30'd0, eb});
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    bit aw_done = 1'b0, w_done = 1'b0, b_seen = 1'b0, b_done = 1'b0;
    int cyc = 0;
    b_q.push_back(exp_resp);
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge ACLK);
      if (AWVALID && AWREADY) aw_done = 1'b1;
      if (WVALID && WREADY) w_done = 1'b1;
      step();
      if (aw_done) AWVALID = 1'b0;
      if (w_done) WVALID = 1'b0;
      cyc++;
    end
    if (!(aw_done && w_done)) timeout("aw_w_handshake");
    cyc = 0;
    while (!b_done && cyc < 50) begin
      @(negedge ACLK);
      if (BVALID && !b_seen) begin
        pad_at_b = pads;
        b_seen = 1'b1;
      end
      if (BVALID && BREADY) b_done = 1'b1;
      step();
      cyc++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    if (!b_done) timeout("b_handshake");
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    rexp_t e;
    bit ar_done = 1'b0, r_done = 1'b0;
    int cyc = 0;
    e.data = exp_data; e.resp = exp_resp;
    r_q.push_back(e);
    ARADDR = addr; ARVALID = 1'b1;
    while (!ar_done && cyc < 50) begin
      @(negedge ACLK);
      if (ARVALID && ARREADY) ar_done = 1'b1;
      step();
      cyc++;
    end
    ARVALID = 1'b0;
    if (!ar_done) timeout("ar_handshake");
    cyc = 0;
    while (!r_done && cyc < 50) begin
      @(negedge ACLK);
      if (RVALID && RREADY) r_done = 1'b1;
      step();
      cyc++;
    end
    if (!r_done) timeout("r_handshake");
  endtask

  initial begin
    int cyc;
    bit ok;
    repeat (3) step();
    ARESET = 1'b0;
    step();

    // Reset state
    check("rst_awready", {31'd0, AWREADY}, 32'd1);
    check("rst_wready",  {31'd0, WREADY},  32'd1);
    check("rst_arready", {31'd0, ARREADY}, 32'd1);
    check("rst_bvalid",  {31'd0, BVALID},  32'd0);
    check("rst_rvalid",  {31'd0, RVALID},  32'd0);
    check("rst_rdata",   RDATA,            32'd0);
    check("rst_irq",     {31'd0, IRQ},     32'd0);
    tb_oe = 8'hFF; tb_val = 8'h5A;
    repeat (3) step();
    check("rst_pads_undriven", {24'd0, pads}, 32'h5A);
    axi_read(5'h08, 32'h5A, 2'b00);
    tb_oe = 8'h00;
    axi_read(5'h00, 32'h0, 2'b00);
    axi_read(5'h04, 32'h0, 2'b00);

    // Drive all outputs
    axi_write(5'h00, 32'hFF, 4'hF, 2'b00);
    check("pads_after_moder", {24'd0, pad_at_b}, 32'h00);
    axi_write(5'h04, 32'hA5, 4'hF, 2'b00);
    check("pads_after_odr", {24'd0, pad_at_b}, 32'hA5);
    axi_read(5'h04, 32'hA5, 2'b00);

    // Mixed direction
    axi_write(5'h00, 32'h0F, 4'hF, 2'b00);
    axi_write(5'h04, 32'h03, 4'hF, 2'b00);
    tb_oe = 8'hF0; tb_val = 8'hC0;
    repeat (2) step();
    check("pads_low_nibble", {28'd0, pads[3:0]}, 32'h3);
    axi_read(5'h08, 32'hC3, 2'b00);
    tb_oe = 8'h00;

    // W three cycles ahead of AW, B held off by BREADY
    BREADY = 1'b0;
    WDATA = 32'h5C; WSTRB = 4'hF; AWADDR = 5'h04; WVALID = 1'b1;
    @(negedge ACLK);
    check("w_first_ready", {31'd0, WREADY}, 32'd1);
    step();
    WVALID = 1'b0;
    @(negedge ACLK);
    check("w_held_blocks", {31'd0, WREADY}, 32'd0);
    check("aw_free", {31'd0, AWREADY}, 32'd1);
    step();
    step();
    AWVALID = 1'b1;
    @(negedge ACLK);
    check("aw_late_ready", {31'd0, AWREADY}, 32'd1);
    step();
    AWVALID = 1'b0;
    step();
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      if (!(BVALID === 1'b1 && BRESP === 2'b00 && AWREADY === 1'b0 && WREADY === 1'b0)) ok = 1'b0;
      step();
    end
    check("b_hold_backpressure", {31'd0, ok}, 32'd1);
    b_q.push_back(2'b00);
    BREADY = 1'b1;
    cyc = 0;
    ok = 1'b0;
    while (!ok && cyc < 20) begin
      @(negedge ACLK);
      if (BVALID && BREADY) ok = 1'b1;
      step();
      cyc++;
    end
    if (!ok) timeout("b_release");
    step();
    check("single_b", {31'd0, BVALID}, 32'd0);
    axi_read(5'h04, 32'h5C, 2'b00);

    // Set / clear / strobes
    axi_write(5'h04, 32'hA4, 4'hF, 2'b00);
    axi_write(5'h0C, 32'h03, 4'hF, 2'b00);
    axi_read(5'h04, 32'hA7, 2'b00);
    axi_write(5'h10, 32'h01, 4'hF, 2'b00);
    axi_read(5'h04, 32'hA6, 2'b00);
    axi_write(5'h04, 32'hFF, 4'h0, 2'b00);
    axi_read(5'h04, 32'hA6, 2'b00);
    axi_write(5'h04, 32'h0000_00FF, 4'h2, 2'b00);
    axi_write(5'h0C, 32'hFF, 4'h0, 2'b00);
    axi_read(5'h04, 32'hA6, 2'b00);

    // Unmapped / interrupt
    axi_read(5'h0C, 32'h0, 2'b00);
    axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, 2'b00);
    axi_read(5'h00, 32'hFF, 2'b00);
`ifdef GPIO_IRQ_EN
    axi_write(5'h00, 32'h00, 4'hF, 2'b00);
    tb_oe = 8'h04; tb_val = 8'h00;
    axi_write(5'h14, 32'h04, 4'hF, 2'b00);
    axi_write(5'h18, 32'h04, 4'hF, 2'b00);
    repeat (4) step();
    tb_val = 8'h04;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("irq_not_early", {31'd0, IRQ}, 32'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    check("irq_rise", {31'd0, IRQ}, 32'd1);
    step();
    axi_write(5'h1C, 32'h04, 4'hF, 2'b00);
    check("irq_cleared", {31'd0, IRQ}, 32'd0);
    axi_read(5'h14, 32'h04, 2'b00);
    tb_oe = 8'h00;
    axi_write(5'h00, 32'hFF, 4'hF, 2'b00);
`else
    axi_read(5'h14, 32'h0, 2'b10);
    axi_read(5'h1C, 32'h0, 2'b10);
    axi_write(5'h18, 32'h12, 4'hF, 2'b10);
    check("irq_tied", {31'd0, IRQ}, 32'd0);
`endif

    // Reset while a read response is pending
    RREADY = 1'b0;
    ARADDR = 5'h00; ARVALID = 1'b1;
    @(negedge ACLK);
    step();
    ARVALID = 1'b0;
    @(negedge ACLK);
    check("rvalid_pending", {31'd0, RVALID}, 32'd1);
    ARESET = 1'b1;
    #1;
    check("rst_rvalid_drop", {31'd0, RVALID}, 32'd0);
    step();
    ARESET = 1'b0;
    RREADY = 1'b1;
    step();
    axi_read(5'h00, 32'h0, 2'b00);
    axi_read(5'h04, 32'h0, 2'b00);

    repeat (3) step();
    if (r_q.size() != 0 || b_q.size() != 0) check("scoreboard_drained", 32'(r_q.size() + b_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
